// File: rtl/int_to_rec_fn_pipe_if.sv
// Handshake bundle for int_to_rec_fn_pipe.
//   master : producer of operations / consumer of results (drives io_in_*, io_out_ready)
//   slave  : the converter (drives io_in_ready, io_out_*)
// Input side : io_in_valid/io_in_ready, io_in_signed, io_in_data, io_in_rm, io_in_tag
// Output side: io_out_valid/io_out_ready, io_out_data (recoded float), io_out_flags, io_out_tag
interface int_to_rec_fn_pipe_if #(
    parameter int INT_WIDTH = 64,
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int TAG_WIDTH = 5
);
    logic                           io_in_valid;
    logic                           io_in_ready;
    logic                           io_in_signed;
    logic [INT_WIDTH-1:0]           io_in_data;
    logic [2:0]                     io_in_rm;
    logic [TAG_WIDTH-1:0]           io_in_tag;
    logic                           io_out_valid;
    logic                           io_out_ready;
    logic [EXP_WIDTH+SIG_WIDTH:0]   io_out_data;
    logic [4:0]                     io_out_flags;
    logic [TAG_WIDTH-1:0]           io_out_tag;

    modport master (
        output io_in_valid, io_in_signed, io_in_data, io_in_rm, io_in_tag, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_data, io_out_flags, io_out_tag
    );

    modport slave (
        input  io_in_valid, io_in_signed, io_in_data, io_in_rm, io_in_tag, io_out_ready,
        output io_in_ready, io_out_valid, io_out_data, io_out_flags, io_out_tag
    );
endinterface

// File: rtl/int_to_rec_fn_pipe.sv
// Three-stage pipelined integer to recoded floating-point converter.
//   S1: sign, magnitude and position of the leading one
//   S2: normalising left shift (leading one moved to the MSB)
//   S3: rounding, overflow handling and recoded packing; outputs come straight from S3 flops
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears only the stage valid bits
//   io    : slave side of int_to_rec_fn_pipe_if (valid/ready in and out, operand,
//           rounding mode, tag, recoded result {sign, exp, fract}, flags
//           {invalid, infinite, overflow, underflow, inexact})
module int_to_rec_fn_pipe #(
    parameter int INT_WIDTH = 64,
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int TAG_WIDTH = 5
) (
    input  logic              clock,
    input  logic              reset,
    int_to_rec_fn_pipe_if.slave io
);

    localparam int KW    = $clog2(INT_WIDTH);
    // Extended width guarantees a guard bit and at least one sticky bit exist
    // even when the integer is narrower than the significand.
    localparam int EXT_W = (INT_WIDTH > SIG_WIDTH + 1) ? INT_WIDTH : SIG_WIDTH + 2;
    localparam int OUT_W = EXP_WIDTH + SIG_WIDTH + 1;

    localparam logic [KW-1:0]      TOP_IDX     = KW'(INT_WIDTH - 1);
    localparam logic [31:0]        MAX_UNB     = (32'd1 << (EXP_WIDTH - 1)) - 32'd1;
    localparam logic [EXP_WIDTH:0] EXP_BASE    = {1'b1, {EXP_WIDTH{1'b0}}};
    localparam logic [EXP_WIDTH:0] EXP_MAX_FIN = EXP_BASE + (EXP_WIDTH + 1)'(MAX_UNB);
    localparam logic [EXP_WIDTH:0] EXP_INF     = {3'b110, {(EXP_WIDTH - 2){1'b0}}};

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [2:0] RM_ODD = 3'd6;

    // ---------------- pipeline control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;
    logic s1_adv, s2_adv, s3_adv;

    assign s3_adv = ~s3_valid_q | io.io_out_ready;
    assign s2_adv = ~s2_valid_q | s3_adv;
    assign s1_adv = ~s1_valid_q | s2_adv;

    always_comb begin
        s1_valid_d = s1_adv ? io.io_in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q     : s2_valid_q;
        s3_valid_d = s3_adv ? s2_valid_q     : s3_valid_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
        end
    end

    // ---------------- S1: sign / magnitude / leading one ----------------
    logic                 in_sign;
    logic [INT_WIDTH-1:0] in_mag;
    logic [KW-1:0]        in_msb;

    logic                 s1_sign_q, s1_sign_d;
    logic [INT_WIDTH-1:0] s1_mag_q,  s1_mag_d;
    logic [KW-1:0]        s1_msb_q,  s1_msb_d;
    logic [2:0]           s1_rm_q,   s1_rm_d;
    logic [TAG_WIDTH-1:0] s1_tag_q,  s1_tag_d;

    always_comb begin
        in_sign = io.io_in_signed & io.io_in_data[INT_WIDTH-1];
        // Negation wraps, so the most-negative value yields 2^(INT_WIDTH-1) as unsigned.
        in_mag  = in_sign ? -io.io_in_data : io.io_in_data;
        in_msb  = '0;
        for (int i = 0; i < INT_WIDTH; i++) begin
            if (in_mag[i]) in_msb = KW'(i);
        end
    end

    always_comb begin
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        s1_msb_d  = s1_msb_q;
        s1_rm_d   = s1_rm_q;
        s1_tag_d  = s1_tag_q;
        if (s1_adv) begin
            s1_sign_d = in_sign;
            s1_mag_d  = in_mag;
            s1_msb_d  = in_msb;
            s1_rm_d   = io.io_in_rm;
            s1_tag_d  = io.io_in_tag;
        end
    end

    // ---------------- S2: normalise ----------------
    logic                 s2_sign_q, s2_sign_d;
    logic [INT_WIDTH-1:0] s2_norm_q, s2_norm_d;
    logic [KW-1:0]        s2_msb_q,  s2_msb_d;
    logic [2:0]           s2_rm_q,   s2_rm_d;
    logic [TAG_WIDTH-1:0] s2_tag_q,  s2_tag_d;

    always_comb begin
        s2_sign_d = s2_sign_q;
        s2_norm_d = s2_norm_q;
        s2_msb_d  = s2_msb_q;
        s2_rm_d   = s2_rm_q;
        s2_tag_d  = s2_tag_q;
        if (s2_adv) begin
            s2_sign_d = s1_sign_q;
            s2_norm_d = s1_mag_q << (TOP_IDX - s1_msb_q);
            s2_msb_d  = s1_msb_q;
            s2_rm_d   = s1_rm_q;
            s2_tag_d  = s1_tag_q;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic [EXT_W-1:0]     ext;
    logic [SIG_WIDTH-1:0] kept;
    logic                 guard, sticky, inexact, nonzero;
    logic [2:0]           rm_eff;
    logic                 rnd_up, carry, ovf, to_zero;
    logic [SIG_WIDTH-2:0] fract_rnd, fract_r;
    logic [31:0]          exp_unb;
    logic [EXP_WIDTH:0]   exp_r;
    logic                 sign_r;

    logic [OUT_W-1:0]     out_data_q,  out_data_d;
    logic [4:0]           out_flags_q, out_flags_d;
    logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;

    always_comb begin
        ext = '0;
        ext[EXT_W-1 -: INT_WIDTH] = s2_norm_q;
        kept    = ext[EXT_W-1 -: SIG_WIDTH];
        guard   = ext[EXT_W-1-SIG_WIDTH];
        sticky  = |ext[EXT_W-2-SIG_WIDTH:0];
        inexact = guard | sticky;
        // A normalised nonzero value always has its MSB set.
        nonzero = s2_norm_q[INT_WIDTH-1];

        rm_eff = (s2_rm_q == 3'd5 || s2_rm_q == 3'd7) ? RM_RNE : s2_rm_q;
        rnd_up = 1'b0;
        case (rm_eff)
            RM_RNE:  rnd_up = guard & (sticky | kept[0]);
            RM_RDN:  rnd_up = inexact & s2_sign_q;
            RM_RUP:  rnd_up = inexact & ~s2_sign_q;
            RM_RMM:  rnd_up = guard;
            default: rnd_up = 1'b0;
        endcase

        // Carry out only when every kept bit is one; the fraction then wraps to zero,
        // which is exactly the renormalised significand.
        carry     = rnd_up & (&kept);
        fract_rnd = kept[SIG_WIDTH-2:0] + (SIG_WIDTH - 1)'(rnd_up);
        if (rm_eff == RM_ODD) fract_rnd[0] = fract_rnd[0] | inexact;

        exp_unb = 32'(s2_msb_q) + 32'(carry);
        ovf     = nonzero & (exp_unb > MAX_UNB);
        to_zero = (rm_eff == RM_RTZ) | ((rm_eff == RM_RDN) & ~s2_sign_q) |
                  ((rm_eff == RM_RUP) & s2_sign_q);

        sign_r  = s2_sign_q & nonzero;
        exp_r   = EXP_BASE + (EXP_WIDTH + 1)'(exp_unb);
        fract_r = fract_rnd;
        if (ovf) begin
            exp_r   = to_zero ? EXP_MAX_FIN : EXP_INF;
            fract_r = to_zero ? '1 : '0;
        end
        if (!nonzero) begin
            exp_r   = '0;
            fract_r = '0;
        end

        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        out_tag_d   = out_tag_q;
        if (s3_adv) begin
            out_data_d  = {sign_r, exp_r, fract_r};
            out_flags_d = {2'b00, ovf, 1'b0, inexact | ovf};
            out_tag_d   = s2_tag_q;
        end
    end

    // Data path flops carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clock) begin
        s1_sign_q   <= s1_sign_d;
        s1_mag_q    <= s1_mag_d;
        s1_msb_q    <= s1_msb_d;
        s1_rm_q     <= s1_rm_d;
        s1_tag_q    <= s1_tag_d;
        s2_sign_q   <= s2_sign_d;
        s2_norm_q   <= s2_norm_d;
        s2_msb_q    <= s2_msb_d;
        s2_rm_q     <= s2_rm_d;
        s2_tag_q    <= s2_tag_d;
        out_data_q  <= out_data_d;
        out_flags_q <= out_flags_d;
        out_tag_q   <= out_tag_d;
    end

    assign io.io_in_ready  = s1_adv;
    assign io.io_out_valid = s3_valid_q;
    assign io.io_out_data  = out_data_q;
    assign io.io_out_flags = out_flags_q;
    assign io.io_out_tag   = out_tag_q;

endmodule

// File: tb/tb_int_to_rec_fn_pipe.sv
// Self-checking bench for int_to_rec_fn_pipe at 64/8/24/5.
// Expected results come from an arithmetic reference model (magnitude, remainder
// versus half-ulp comparison) and from hand-derived directed vectors.
module tb_int_to_rec_fn_pipe;
    localparam int IW = 64;
    localparam int EW = 8;
    localparam int SW = 24;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    int_to_rec_fn_pipe_if #(.INT_WIDTH(IW), .EXP_WIDTH(EW), .SIG_WIDTH(SW), .TAG_WIDTH(TW)) io_if ();

    int_to_rec_fn_pipe #(.INT_WIDTH(IW), .EXP_WIDTH(EW), .SIG_WIDTH(SW), .TAG_WIDTH(TW)) dut (
        .clock (clk),
        .reset (rst),
        .io    (io_if.slave)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic [2:0]  rm;
        logic [4:0]  tag;
        logic [32:0] ed;
        logic [4:0]  ef;
    } vec_t;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic [2:0]  rm;
        logic [4:0]  tag;
    } op_t;

    typedef struct packed {
        logic [32:0] d;
        logic [4:0]  f;
        logic [4:0]  t;
        logic [31:0] acc;
    } exp_t;

    // Returns {recoded[32:0], flags[4:0]}.
    function automatic logic [37:0] ref_model(input logic [63:0] d, input logic s, input logic [2:0] rm);
        logic        neg, inexact, up;
        logic [63:0] mag, sig, rem, half;
        logic [2:0]  mode;
        logic [8:0]  e;
        int          k, sh;
        neg = s && d[63];
        mag = neg ? (64'd0 - d) : d;
        if (mag == 64'd0) return 38'd0;
        k = 0;
        while (k < 63 && (mag >> (k + 1)) != 64'd0) k++;
        rem  = 64'd0;
        half = 64'd0;
        if (k <= 23) begin
            sig = mag << (23 - k);
        end else begin
            sh   = k - 23;
            sig  = mag >> sh;
            rem  = mag - (sig << sh);
            half = 64'd1 << (sh - 1);
        end
        inexact = (rem != 64'd0);
        mode = (rm == 3'd5 || rm == 3'd7) ? 3'd0 : rm;
        case (mode)
            3'd0:    up = inexact && (rem > half || (rem == half && sig[0]));
            3'd2:    up = inexact && neg;
            3'd3:    up = inexact && !neg;
            3'd4:    up = inexact && (rem >= half);
            default: up = 1'b0;
        endcase
        sig = sig + 64'(up);
        if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            k++;
        end
        if (mode == 3'd6 && inexact) sig[0] = 1'b1;
        e = 9'(256 + k);
        return {neg, e, sig[22:0], 4'b0000, inexact};
    endfunction

    function automatic logic [63:0] rand_data();
        logic [63:0] base;
        logic [31:0] a, b;
        int          sh;
        case ($urandom_range(0, 3))
            0: begin
                a = $urandom();
                b = $urandom();
                base = {a, b};
                return base >> $urandom_range(0, 63);
            end
            1: begin
                sh   = $urandom_range(1, 40);
                base = 64'($urandom_range(0, (1 << 23) - 1)) | (64'd1 << 23);
                return (base << sh) | (64'd1 << (sh - 1));
            end
            2: begin
                base = ~64'd0;
                return base >> $urandom_range(0, 40);
            end
            default: return 64'($urandom_range(0, (1 << 24) + 4));
        endcase
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.d   = rand_data();
        o.s   = 1'($urandom_range(0, 1));
        o.rm  = 3'($urandom_range(0, 7));
        o.tag = 5'($urandom_range(0, 31));
        return o;
    endfunction

    task automatic idle_inputs();
        io_if.io_in_valid  = 1'b0;
        io_if.io_in_signed = 1'b0;
        io_if.io_in_data   = '0;
        io_if.io_in_rm     = 3'd0;
        io_if.io_in_tag    = '0;
        io_if.io_out_ready = 1'b1;
    endtask

    // Issues one operation into an empty pipeline and waits for its result.
    // lat counts rising edges from the accepting edge (inclusive); -1 on timeout.
    task automatic exec_op(input op_t o, output int lat, output logic [32:0] od,
                           output logic [4:0] of, output logic [4:0] ot);
        bit got;
        got = 1'b0;
        lat = -1;
        od  = 'x;
        of  = 'x;
        ot  = 'x;
        @(posedge clk); #1;
        io_if.io_in_valid  = 1'b1;
        io_if.io_in_signed = o.s;
        io_if.io_in_data   = o.d;
        io_if.io_in_rm     = o.rm;
        io_if.io_in_tag    = o.tag;
        io_if.io_out_ready = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk); #1;
            io_if.io_in_valid = 1'b0;
            io_if.io_in_data  = ~o.d;
            io_if.io_in_rm    = ~o.rm;
            io_if.io_in_tag   = ~o.tag;
            #1;
            if (io_if.io_out_valid) begin
                got = 1'b1;
                lat = c;
                od  = io_if.io_out_data;
                of  = io_if.io_out_flags;
                ot  = io_if.io_out_tag;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (io_if.io_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", io_if.io_out_valid);
        end
        checks++;
        if (io_if.io_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", io_if.io_in_ready);
        end
        @(posedge clk); #2;
        checks++;
        if (io_if.io_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid_idle: got %b expected 0", io_if.io_out_valid);
        end
        checks++;
        if (io_if.io_in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_idle: got %b expected 1", io_if.io_in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t        v[$];
        op_t         o;
        int          lat;
        logic [32:0] od;
        logic [4:0]  of, ot;
        v.push_back({64'd1,                  1'b0, 3'd0, 5'd3,  33'h080000000, 5'h00});
        v.push_back({64'hFFFFFFFFFFFFFFFF,   1'b1, 3'd0, 5'd7,  33'h180000000, 5'h00});
        v.push_back({64'd16777217,           1'b0, 3'd0, 5'd9,  33'h08C000000, 5'h01});
        v.push_back({64'd16777217,           1'b0, 3'd1, 5'd10, 33'h08C000000, 5'h01});
        v.push_back({64'd16777217,           1'b0, 3'd3, 5'd11, 33'h08C000001, 5'h01});
        v.push_back({64'd16777217,           1'b0, 3'd4, 5'd12, 33'h08C000001, 5'h01});
        v.push_back({64'd16777217,           1'b0, 3'd6, 5'd13, 33'h08C000001, 5'h01});
        v.push_back({64'd16777218,           1'b0, 3'd6, 5'd14, 33'h08C000001, 5'h00});
        v.push_back({64'd16777219,           1'b0, 3'd0, 5'd15, 33'h08C000002, 5'h01});
        v.push_back({64'd16777219,           1'b0, 3'd1, 5'd16, 33'h08C000001, 5'h01});
        v.push_back({64'd16777215,           1'b0, 3'd0, 5'd17, 33'h08BFFFFFF, 5'h00});
        v.push_back({64'hFFFFFFFFFEFFFFFF,   1'b1, 3'd2, 5'd18, 33'h18C000001, 5'h01});
        v.push_back({64'hFFFFFFFFFFFFFFFF,   1'b0, 3'd0, 5'd19, 33'h0A0000000, 5'h01});
        v.push_back({64'h8000000000000000,   1'b1, 3'd0, 5'd20, 33'h19F800000, 5'h00});
        for (int m = 0; m < 8; m++) begin
            v.push_back({64'd0, 1'(m & 1), 3'(m), 5'(m), 33'h000000000, 5'h00});
        end
        foreach (v[i]) begin
            o = {v[i].d, v[i].s, v[i].rm, v[i].tag};
            exec_op(o, lat, od, of, ot);
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d expected 3", i, lat);
            end
            checks++;
            if (od !== v[i].ed) begin
                errors++; $display("FAIL directed_data[%0d]: got %h expected %h", i, od, v[i].ed);
            end
            checks++;
            if (of !== v[i].ef) begin
                errors++; $display("FAIL directed_flags[%0d]: got %h expected %h", i, of, v[i].ef);
            end
            checks++;
            if (ot !== v[i].tag) begin
                errors++; $display("FAIL directed_tag[%0d]: got %h expected %h", i, ot, v[i].tag);
            end
        end
    endtask

    task automatic test_random(input int n);
        op_t         o;
        int          lat;
        logic [32:0] od;
        logic [4:0]  of, ot;
        logic [37:0] r;
        for (int i = 0; i < n; i++) begin
            o = rand_op();
            r = ref_model(o.d, o.s, o.rm);
            exec_op(o, lat, od, of, ot);
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL random_latency[%0d]: got %0d expected 3", i, lat);
            end
            checks++;
            if (od !== r[37:5] || of !== r[4:0] || ot !== o.tag) begin
                errors++;
                $display("FAIL random_result[%0d] in=%h s=%b rm=%0d: got %h/%h/%h expected %h/%h/%h",
                         i, o.d, o.s, o.rm, od, of, ot, r[37:5], r[4:0], o.tag);
            end
        end
    endtask

    // Streams n operations back to back; with stall set, io_out_ready is random.
    task automatic test_stream(input int n, input bit stall);
        op_t         ops[$];
        exp_t        q[$];
        exp_t        e;
        logic [37:0] r;
        int          idx, delivered, occ, cyc;
        bit          prev_stall, exp_ready;
        logic [32:0] pd;
        logic [4:0]  pf, pt;
        for (int i = 0; i < n; i++) ops.push_back(rand_op());
        idx = 0; delivered = 0; occ = 0; cyc = 0; prev_stall = 1'b0;
        pd = '0; pf = '0; pt = '0;
        while (delivered < n && cyc < 2000) begin
            @(posedge clk); #1;
            io_if.io_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < n) begin
                io_if.io_in_valid  = 1'b1;
                io_if.io_in_signed = ops[idx].s;
                io_if.io_in_data   = ops[idx].d;
                io_if.io_in_rm     = ops[idx].rm;
                io_if.io_in_tag    = ops[idx].tag;
            end else begin
                io_if.io_in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (io_if.io_out_valid !== 1'b1 || io_if.io_out_data !== pd ||
                    io_if.io_out_flags !== pf || io_if.io_out_tag !== pt) begin
                    errors++;
                    $display("FAIL stream_hold cyc=%0d: got %b/%h/%h/%h expected 1/%h/%h/%h", cyc,
                             io_if.io_out_valid, io_if.io_out_data, io_if.io_out_flags, io_if.io_out_tag,
                             pd, pf, pt);
                end
            end
            exp_ready = !(occ == 3 && !io_if.io_out_ready);
            checks++;
            if (io_if.io_in_ready !== exp_ready) begin
                errors++;
                $display("FAIL stream_in_ready cyc=%0d occ=%0d: got %b expected %b", cyc, occ,
                         io_if.io_in_ready, exp_ready);
            end
            if (io_if.io_out_valid === 1'b1 && io_if.io_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_spurious cyc=%0d: got result %h expected none", cyc,
                                       io_if.io_out_data);
                end else begin
                    e = q.pop_front();
                    if (io_if.io_out_data !== e.d || io_if.io_out_flags !== e.f || io_if.io_out_tag !== e.t) begin
                        errors++;
                        $display("FAIL stream_result[%0d]: got %h/%h/%h expected %h/%h/%h", delivered,
                                 io_if.io_out_data, io_if.io_out_flags, io_if.io_out_tag, e.d, e.f, e.t);
                    end
                    if (!stall) begin
                        checks++;
                        if (cyc - int'(e.acc) != 3) begin
                            errors++; $display("FAIL stream_latency[%0d]: got %0d expected 3", delivered,
                                               cyc - int'(e.acc));
                        end
                    end
                end
                delivered++;
                occ--;
            end
            prev_stall = (io_if.io_out_valid === 1'b1) && !io_if.io_out_ready;
            pd = io_if.io_out_data;
            pf = io_if.io_out_flags;
            pt = io_if.io_out_tag;
            if (io_if.io_in_valid && io_if.io_in_ready === 1'b1) begin
                r = ref_model(ops[idx].d, ops[idx].s, ops[idx].rm);
                q.push_back({r[37:5], r[4:0], ops[idx].tag, 32'(cyc)});
                idx++;
                occ++;
            end
            cyc++;
        end
        io_if.io_in_valid  = 1'b0;
        io_if.io_out_ready = 1'b1;
        checks++;
        if (delivered != n) begin
            errors++; $display("FAIL stream_complete: got %0d results expected %0d", delivered, n);
        end
    endtask

    task automatic test_reset_midflight();
        op_t         o;
        int          lat;
        logic [32:0] od;
        logic [4:0]  of, ot;
        logic [37:0] r;
        @(posedge clk); #1;
        io_if.io_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            o = rand_op();
            io_if.io_in_valid  = 1'b1;
            io_if.io_in_signed = o.s;
            io_if.io_in_data   = o.d;
            io_if.io_in_rm     = o.rm;
            io_if.io_in_tag    = o.tag;
            @(posedge clk); #1;
        end
        io_if.io_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        io_if.io_out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (io_if.io_out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_out_valid cyc=%0d: got %b expected 0", c, io_if.io_out_valid);
            end
            @(posedge clk); #2;
        end
        o = rand_op();
        r = ref_model(o.d, o.s, o.rm);
        exec_op(o, lat, od, of, ot);
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL flush_latency: got %0d expected 3", lat);
        end
        checks++;
        if (od !== r[37:5] || of !== r[4:0] || ot !== o.tag) begin
            errors++;
            $display("FAIL flush_result: got %h/%h/%h expected %h/%h/%h", od, of, ot, r[37:5], r[4:0], o.tag);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_directed();
        test_random(60);
        test_stream(10, 1'b0);
        test_stream(10, 1'b1);
        test_stream(40, 1'b1);
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
